// File: rtl/bias_relu_stage.sv
// bias_relu_stage: post-processing stage behind the matrix-multiply engine.
// It takes the row-major result stream, adds a per-column bias, rescales,
// applies ReLU and saturation, and writes the result to the activation buffer.
// The pipeline has four register stages: capture, wait-for-bias, sum, output.
module bias_relu_stage #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 16,
   parameter int DIM_W     = 10,
   parameter int FRAC_BITS = 0,
   parameter int RELU_EN   = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DIM_W-1:0]  m,
   input  logic [DIM_W-1:0]  n,
   input  logic              in_valid,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [DATA_W-1:0] in_data,
   input  logic              mm_done,
   output logic [DIM_W-1:0]  bias_addr,
   input  logic [DATA_W-1:0] bias_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data,
   output logic              out_we,
   output logic              done,
   output logic              err
);

   localparam int CNT_W = 2 * DIM_W;

   // Saturation limits expressed at the widened sum precision.
   localparam logic signed [DATA_W:0] MAX_V = {2'b00, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W:0] MIN_V = {2'b11, {(DATA_W-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      FINISH
   } state_t;

   state_t            state;
   logic [DIM_W-1:0]  n_lat;
   logic [DIM_W-1:0]  col;
   logic [CNT_W-1:0]  total;
   logic [CNT_W-1:0]  cnt;

   // Stage 0: word captured when accepted; the bias read is launched at the same edge.
   logic              p0_valid;
   logic [DATA_W-1:0] p0_data;
   logic [ADDR_W-1:0] p0_addr;

   // Stage 1: data held one more cycle while the bias RAM responds.
   logic              p1_valid;
   logic [DATA_W-1:0] p1_data;
   logic [ADDR_W-1:0] p1_addr;

   // Stage 2: full-precision bias sum.
   logic              p2_valid;
   logic signed [DATA_W:0] p2_sum;
   logic [ADDR_W-1:0] p2_addr;

   logic              accept;
   logic              pipe_empty;
   logic signed [DATA_W:0] shifted;
   logic [DATA_W-1:0] sat_value;

   // A word enters the pipeline only while running and before the pass is full.
   assign accept     = (state == RUN) && in_valid && (cnt != total);
   assign pipe_empty = !p0_valid && !p1_valid && !p2_valid && !out_we;

   // Pass control: start latching, counters, error detection and done signalling.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         n_lat <= '0;
         col   <= '0;
         total <= '0;
         cnt   <= '0;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  n_lat <= n;
                  total <= {{DIM_W{1'b0}}, m} * {{DIM_W{1'b0}}, n};
                  col   <= '0;
                  cnt   <= '0;
                  done  <= 1'b0;
                  err   <= 1'b0;
                  state <= RUN;
               end
            end
            RUN: begin
               if (in_valid) begin
                  if (cnt == total) begin
                     err <= 1'b1;
                  end else begin
                     if (CNT_W'(in_addr) != cnt) begin
                        err <= 1'b1;
                     end
                     cnt <= cnt + CNT_W'(1);
                     if (col == n_lat - DIM_W'(1)) begin
                        col <= '0;
                     end else begin
                        col <= col + DIM_W'(1);
                     end
                  end
               end
               if (cnt == total) begin
                  state <= DRAIN;
               end else if (mm_done) begin
                  err   <= 1'b1;
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (pipe_empty) begin
                  done  <= 1'b1;
                  state <= FINISH;
               end
            end
            FINISH: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Rescale, then clamp: negatives go to zero under ReLU, otherwise saturate both ends.
   always_comb begin
      shifted = p2_sum >>> FRAC_BITS;
      if ((RELU_EN != 0) && shifted[DATA_W]) begin
         sat_value = '0;
      end else if (shifted > MAX_V) begin
         sat_value = MAX_V[DATA_W-1:0];
      end else if (shifted < MIN_V) begin
         sat_value = MIN_V[DATA_W-1:0];
      end else begin
         sat_value = shifted[DATA_W-1:0];
      end
   end

   // Datapath pipeline: capture, bias wait, sum, and registered activation write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p0_valid  <= 1'b0;
         p0_data   <= '0;
         p0_addr   <= '0;
         p1_valid  <= 1'b0;
         p1_data   <= '0;
         p1_addr   <= '0;
         p2_valid  <= 1'b0;
         p2_sum    <= '0;
         p2_addr   <= '0;
         bias_addr <= '0;
         out_we    <= 1'b0;
         out_data  <= '0;
         out_addr  <= '0;
      end else begin
         p0_valid <= accept;
         if (accept) begin
            p0_data   <= in_data;
            p0_addr   <= ADDR_W'(cnt);
            bias_addr <= col;
         end

         p1_valid <= p0_valid;
         if (p0_valid) begin
            p1_data <= p0_data;
            p1_addr <= p0_addr;
         end

         p2_valid <= p1_valid;
         if (p1_valid) begin
            p2_sum  <= {p1_data[DATA_W-1], p1_data} + {bias_data[DATA_W-1], bias_data};
            p2_addr <= p1_addr;
         end

         out_we <= p2_valid;
         if (p2_valid) begin
            out_data <= sat_value;
            out_addr <= p2_addr;
         end
      end
   end

endmodule

// File: tb/tb_bias_relu_stage.sv
// tb_bias_relu_stage: directed bench for bias_relu_stage.
// Three instances share the stimulus: FRAC_BITS=0/RELU_EN=1, FRAC_BITS=0/RELU_EN=0,
// and FRAC_BITS=4/RELU_EN=1, each with its own synchronous bias RAM model.
module tb_bias_relu_stage;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 16;
   localparam int DIM_W  = 10;
   localparam int NDUT   = 3;
   localparam int CAPN   = 64;

   typedef struct packed {
      logic [31:0] data;
      logic [31:0] bias;
      logic [31:0] exp0;
      logic [31:0] exp1;
      logic [31:0] exp2;
   } vec_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic [DIM_W-1:0]  m;
   logic [DIM_W-1:0]  n;
   logic              in_valid;
   logic [ADDR_W-1:0] in_addr;
   logic [DATA_W-1:0] in_data;
   logic              mm_done;

   logic [DATA_W-1:0] bias_mem [1024];

   logic [DIM_W-1:0]  bias_addr_w [NDUT];
   logic [ADDR_W-1:0] out_addr_w  [NDUT];
   logic [DATA_W-1:0] out_data_w  [NDUT];
   logic              out_we_w    [NDUT];
   logic              done_w      [NDUT];
   logic              err_w       [NDUT];

   logic [DATA_W-1:0] cap_data [NDUT][CAPN];
   logic [ADDR_W-1:0] cap_addr [NDUT][CAPN];
   int                cap_cyc  [NDUT][CAPN];
   int                cap_cnt  [NDUT] = '{0, 0, 0};
   int                base     [NDUT];
   int                cyc = 0;

   logic [DATA_W-1:0] stim_data [16];
   logic [ADDR_W-1:0] stim_addr [16];
   int                first_cyc;
   int                done_wait;
   int                n_vec  = 0;
   int                n_fail = 0;
   vec_t              vecs [9];

   always #5 clk = ~clk;

   // Free-running cycle counter used for latency and back-to-back timing checks.
   always @(posedge clk) cyc <= cyc + 1;

   genvar g;
   for (g = 0; g < NDUT; g++) begin : g_dut
      logic [DIM_W-1:0]  ba;
      logic [DATA_W-1:0] bd;
      logic [DATA_W-1:0] od;
      logic [ADDR_W-1:0] oa;
      logic              we;
      logic              dn;
      logic              er;

      // Synchronous bias RAM: read data appears one cycle after the address is sampled.
      always @(posedge clk) bd <= bias_mem[ba];

      bias_relu_stage #(
         .DATA_W   (DATA_W),
         .ADDR_W   (ADDR_W),
         .DIM_W    (DIM_W),
         .FRAC_BITS(g == 2 ? 4 : 0),
         .RELU_EN  (g == 1 ? 0 : 1)
      ) dut (
         .clk      (clk),
         .rst_n    (rst_n),
         .start    (start),
         .m        (m),
         .n        (n),
         .in_valid (in_valid),
         .in_addr  (in_addr),
         .in_data  (in_data),
         .mm_done  (mm_done),
         .bias_addr(ba),
         .bias_data(bd),
         .out_addr (oa),
         .out_data (od),
         .out_we   (we),
         .done     (dn),
         .err      (er)
      );

      assign bias_addr_w[g] = ba;
      assign out_addr_w[g]  = oa;
      assign out_data_w[g]  = od;
      assign out_we_w[g]    = we;
      assign done_w[g]      = dn;
      assign err_w[g]       = er;
   end

   // Record every activation write of every instance, away from the active edge.
   always @(negedge clk) begin
      for (int k = 0; k < NDUT; k++) begin
         if (out_we_w[k] === 1'b1 && cap_cnt[k] < CAPN) begin
            cap_data[k][cap_cnt[k]] = out_data_w[k];
            cap_addr[k][cap_cnt[k]] = out_addr_w[k];
            cap_cyc[k][cap_cnt[k]]  = cyc;
            cap_cnt[k]              = cap_cnt[k] + 1;
         end
      end
   end

   // Safety net so the run always ends even if the design locks up.
   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not complete, got hang, expected finish");
      $fatal(1, "[TB] timeout");
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_vec = n_vec + 1;
      if (actual !== expected) begin
         n_fail = n_fail + 1;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // One pass: start with m,n, stream nwords back-to-back, raise mm_done, wait for done.
   // A start pulse with m=n=0 is injected alongside word mid_start (negative: none).
   task automatic applyStimulus(input int m_v, input int n_v, input int nwords, input int mid_start);
      for (int k = 0; k < NDUT; k++) base[k] = cap_cnt[k];
      m     = DIM_W'(m_v);
      n     = DIM_W'(n_v);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < nwords; i++) begin
         in_valid = 1'b1;
         in_addr  = stim_addr[i];
         in_data  = stim_data[i];
         if (i == 0) first_cyc = cyc;
         if (i == mid_start) begin
            start = 1'b1;
            m     = '0;
            n     = '0;
         end
         @(negedge clk);
         start = 1'b0;
      end
      in_valid = 1'b0;
      mm_done  = 1'b1;
      done_wait = 0;
      while (done_wait < 100 && done_w[0] !== 1'b1) begin
         @(negedge clk);
         done_wait = done_wait + 1;
      end
      checkOutput("pass_done", {63'd0, done_w[0]}, 64'd1);
      mm_done = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      // Single-word passes (m=n=1): {data, bias, exp FRAC0/RELU1, exp FRAC0/RELU0, exp FRAC4/RELU1}
      vecs[0] = '{32'h7FFFFFF0, 32'h00000100, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0800000F};
      vecs[1] = '{32'h80000010, 32'hFFFFFF00, 32'h00000000, 32'h80000000, 32'h00000000};
      vecs[2] = '{32'h00000100, 32'h00000010, 32'h00000110, 32'h00000110, 32'h00000011};
      vecs[3] = '{32'h00000005, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFFD, 32'h00000000};
      vecs[4] = '{32'h7FFFFFFF, 32'h00000000, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h07FFFFFF};
      vecs[5] = '{32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 32'h00000000};
      vecs[6] = '{32'h80000000, 32'h00000000, 32'h00000000, 32'h80000000, 32'h00000000};
      vecs[7] = '{32'h12345678, 32'h11111111, 32'h23456789, 32'h23456789, 32'h02345678};
      vecs[8] = '{32'hFFFFFFF0, 32'h00000020, 32'h00000010, 32'h00000010, 32'h00000001};

      for (int i = 0; i < 1024; i++) bias_mem[i] = '0;
      rst_n    = 1'b0;
      start    = 1'b0;
      m        = '0;
      n        = '0;
      in_valid = 1'b0;
      in_addr  = '0;
      in_data  = '0;
      mm_done  = 1'b0;
      repeat (3) @(negedge clk);

      $display("[TB] reset state");
      checkOutput("rst_out_we", {63'd0, out_we_w[0]}, 64'd0);
      checkOutput("rst_done", {63'd0, done_w[0]}, 64'd0);
      checkOutput("rst_err", {63'd0, err_w[0]}, 64'd0);
      checkOutput("rst_out_data", {32'd0, out_data_w[0]}, 64'd0);
      checkOutput("rst_out_addr", {48'd0, out_addr_w[0]}, 64'd0);
      checkOutput("rst_bias_addr", {54'd0, bias_addr_w[0]}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] 2x3 pass, bias {10,-20,5}, back-to-back input");
      bias_mem[0] = 32'd10;
      bias_mem[1] = 32'hFFFFFFEC;
      bias_mem[2] = 32'd5;
      for (int i = 0; i < 6; i++) begin
         stim_data[i] = 32'(i + 1);
         stim_addr[i] = 16'(i);
      end
      applyStimulus(2, 3, 6, -1);
      begin
         logic [31:0] exp_t1 [6];
         exp_t1 = '{32'd11, 32'd0, 32'd8, 32'd14, 32'd0, 32'd11};
         checkOutput("t1_count", 64'(cap_cnt[0] - base[0]), 64'd6);
         for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("t1_data%0d", i), {32'd0, cap_data[0][base[0] + i]}, {32'd0, exp_t1[i]});
            checkOutput($sformatf("t1_addr%0d", i), {48'd0, cap_addr[0][base[0] + i]}, 64'(i));
         end
      end
      // First write is seen after the third edge following the first accepted word.
      checkOutput("t2_latency", 64'(cap_cyc[0][base[0]] - first_cyc), 64'd4);
      checkOutput("t2_burst", 64'(cap_cyc[0][base[0] + 5] - cap_cyc[0][base[0]]), 64'd5);
      checkOutput("t1_err", {63'd0, err_w[0]}, 64'd0);

      $display("[TB] start pulse during RUN is ignored");
      applyStimulus(2, 3, 6, 2);
      checkOutput("t6_count", 64'(cap_cnt[0] - base[0]), 64'd6);
      checkOutput("t6_last_data", {32'd0, cap_data[0][base[0] + 5]}, 64'd11);
      checkOutput("t6_last_addr", {48'd0, cap_addr[0][base[0] + 5]}, 64'd5);
      checkOutput("t6_err", {63'd0, err_w[0]}, 64'd0);

      $display("[TB] mm_done after 4 of 6 words");
      applyStimulus(2, 3, 4, -1);
      checkOutput("t5_count", 64'(cap_cnt[0] - base[0]), 64'd4);
      checkOutput("t5_err", {63'd0, err_w[0]}, 64'd1);
      checkOutput("t5_done", {63'd0, done_w[0]}, 64'd1);

      $display("[TB] extra word after the pass is full");
      stim_data[0] = 32'd1;
      stim_data[1] = 32'd2;
      stim_addr[0] = 16'd0;
      stim_addr[1] = 16'd1;
      applyStimulus(1, 1, 2, -1);
      checkOutput("drop_count", 64'(cap_cnt[0] - base[0]), 64'd1);
      checkOutput("drop_err", {63'd0, err_w[0]}, 64'd1);

      $display("[TB] out-of-order address with FRAC_BITS=4");
      bias_mem[0] = 32'h10;
      bias_mem[1] = 32'h10;
      stim_data[0] = 32'h100;
      stim_data[1] = 32'h100;
      stim_addr[0] = 16'd0;
      stim_addr[1] = 16'd2;
      applyStimulus(1, 2, 2, -1);
      checkOutput("t4_count", 64'(cap_cnt[2] - base[2]), 64'd2);
      checkOutput("t4_data0", {32'd0, cap_data[2][base[2]]}, 64'h11);
      checkOutput("t4_data1", {32'd0, cap_data[2][base[2] + 1]}, 64'h11);
      checkOutput("t4_addr0", {48'd0, cap_addr[2][base[2]]}, 64'd0);
      checkOutput("t4_addr1", {48'd0, cap_addr[2][base[2] + 1]}, 64'd1);
      checkOutput("t4_err", {63'd0, err_w[2]}, 64'd1);

      $display("[TB] m=0 pass");
      applyStimulus(0, 3, 0, -1);
      checkOutput("t6_m0_count", 64'(cap_cnt[0] - base[0]), 64'd0);
      checkOutput("t6_m0_quick", 64'(done_wait <= 3), 64'd1);
      checkOutput("t6_m0_err", {63'd0, err_w[0]}, 64'd0);

      $display("[TB] reset asserted mid-pass");
      bias_mem[0] = 32'd10;
      bias_mem[1] = 32'hFFFFFFEC;
      bias_mem[2] = 32'd5;
      m     = 10'd2;
      n     = 10'd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_addr  = (i == 1) ? 16'd5 : 16'(i);
         in_data  = 32'(i + 1);
         @(negedge clk);
      end
      in_valid = 1'b0;
      checkOutput("mid_out_we", {63'd0, out_we_w[0]}, 64'd1);
      checkOutput("mid_err", {63'd0, err_w[0]}, 64'd1);
      checkOutput("mid_bias_addr", {54'd0, bias_addr_w[0]}, 64'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("rst2_out_we", {63'd0, out_we_w[0]}, 64'd0);
      checkOutput("rst2_out_data", {32'd0, out_data_w[0]}, 64'd0);
      checkOutput("rst2_out_addr", {48'd0, out_addr_w[0]}, 64'd0);
      checkOutput("rst2_bias_addr", {54'd0, bias_addr_w[0]}, 64'd0);
      checkOutput("rst2_err", {63'd0, err_w[0]}, 64'd0);
      checkOutput("rst2_done", {63'd0, done_w[0]}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] single-word saturation and rescale table");
      for (int v = 0; v < 9; v++) begin
         bias_mem[0] = vecs[v].bias;
         stim_data[0] = vecs[v].data;
         stim_addr[0] = 16'd0;
         applyStimulus(1, 1, 1, -1);
         for (int k = 0; k < NDUT; k++) begin
            logic [31:0] exp_k;
            exp_k = (k == 0) ? vecs[v].exp0 : (k == 1) ? vecs[v].exp1 : vecs[v].exp2;
            checkOutput($sformatf("vec%0d_dut%0d_count", v, k), 64'(cap_cnt[k] - base[k]), 64'd1);
            checkOutput($sformatf("vec%0d_dut%0d_data", v, k), {32'd0, cap_data[k][base[k]]}, {32'd0, exp_k});
         end
         checkOutput($sformatf("vec%0d_err", v), {63'd0, err_w[0]}, 64'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
